// File: rtl/fft_frame_sequencer_if.sv
// Streaming sample ports of the FFT frame sequencer: one input stream, one output stream.
// A word moves on a rising edge only when valid and ready are both high; valid and data hold until then.
interface fft_frame_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Loads one bit-reversed frame into a parallel FFT core, waits out its latency,
// then streams the captured result in natural order. One frame in flight at a time.
module fft_frame_sequencer #(
    parameter int N_POINTS = 64,
    parameter int LOG2_N   = 6,
    parameter int CORE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    fft_frame_sequencer_if.slave     bus,
    output logic [16*N_POINTS-1:0]   fft_in,
    input  logic [16*N_POINTS-1:0]   fft_out,
    output logic                     busy,
    output logic [7:0]               frames_done,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [LOG2_N-1:0]        wr_cnt_q, wr_cnt_d;
    logic [LOG2_N-1:0]        rd_cnt_q, rd_cnt_d;
    logic [LOG2_N-1:0]        lat_cnt_q, lat_cnt_d;
    logic [16*N_POINTS-1:0]   fft_in_q, fft_in_d;
    logic [16*N_POINTS-1:0]   cap_q, cap_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic [7:0]               frames_done_q, frames_done_d;
    logic                     in_accept;
    logic                     out_accept;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign in_accept  = bus.in_valid && in_ready_q;
    assign out_accept = out_valid_q && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        fft_in_d      = fft_in_q;
        cap_d         = cap_q;
        out_valid_d   = out_valid_q;
        busy_d        = busy_q;
        frames_done_d = frames_done_q;

        case (state_q)
            ST_LOAD: begin
                if (in_accept) begin
                    fft_in_d[16*int'(bitrev(wr_cnt_q)) +: 16] = bus.in_data;
                    if (wr_cnt_q == LOG2_N'(N_POINTS-1)) begin
                        state_d   = ST_WAIT;
                        wr_cnt_d  = '0;
                        // Sampling one edge after the nominal core latency gives a full
                        // cycle of margin; out_valid rises CORE_LAT+1 edges after the last accept.
                        lat_cnt_d = LOG2_N'(CORE_LAT);
                        busy_d    = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    cap_d       = fft_out;
                    state_d     = ST_UNLOAD;
                    out_valid_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (out_accept) begin
                    if (rd_cnt_q == LOG2_N'(N_POINTS-1)) begin
                        state_d       = ST_LOAD;
                        rd_cnt_d      = '0;
                        out_valid_d   = 1'b0;
                        busy_d        = 1'b0;
                        frames_done_d = frames_done_q + 8'd1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Ready is registered so the turnaround back to LOAD costs no idle cycle.
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_LOAD;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            fft_in_q      <= '0;
            cap_q         <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frames_done_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            fft_in_q      <= fft_in_d;
            cap_q         <= cap_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = cap_q[16*int'(rd_cnt_q) +: 16];
    assign bus.out_last  = out_valid_q && (rd_cnt_q == LOG2_N'(N_POINTS-1));
    assign fft_in        = fft_in_q;
    assign busy          = busy_q;
    assign frames_done   = frames_done_q;
    assign dbg_state     = state_q;

endmodule
